// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: walks each instruction through fetch, decode,
// execute and writeback. It drives the shared datapath selects, keeps the NZCV
// flags and gates architectural writes by the instruction's condition.
module multicycle_controller #(
    parameter logic [3:0] ALWAYS_COND = 4'b1110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [3:0] flags;
    logic       cond_ok;
    logic       cond_now;
    logic       illegal_q;

    logic       cmd_legal;
    logic [1:0] alu_op;
    logic       is_store;
    logic       in_exec;

    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       done_raw;

    // ARM condition evaluation against an NZCV value.
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n;
        logic z;
        logic cy;
        logic v;
        logic r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        if (c == ALWAYS_COND) begin
            r = 1'b1;
        end else begin
            case (c)
                4'b0000: r = z;
                4'b0001: r = ~z;
                4'b0010: r = cy;
                4'b0011: r = ~cy;
                4'b0100: r = n;
                4'b0101: r = ~n;
                4'b0110: r = v;
                4'b0111: r = ~v;
                4'b1000: r = cy & ~z;
                4'b1001: r = ~cy | z;
                4'b1010: r = (n == v);
                4'b1011: r = (n != v);
                4'b1100: r = ~z & (n == v);
                4'b1101: r = z | (n != v);
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

    assign cond_now = cond_check(Cond, flags);
    assign is_store = (Op == 2'b01) && !Funct[0];
    assign in_exec  = (state == EXECR) || (state == EXECI);

    // Translate the data-processing cmd field into an ALU operation and legality.
    always_comb begin
        cmd_legal = 1'b1;
        alu_op    = 2'b00;
        case (Funct[4:1])
            4'b0100: alu_op = 2'b00;
            4'b0010: alu_op = 2'b01;
            4'b0000: alu_op = 2'b10;
            4'b1100: alu_op = 2'b11;
            default: begin
                cmd_legal = 1'b0;
                alu_op    = 2'b00;
            end
        endcase
    end

    // State register; an asynchronous reset abandons the current instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Condition outcome frozen at decode so a flag-setting instruction cannot
    // change its own writeback decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_ok <= 1'b0;
        end else if (state == DECODE) begin
            cond_ok <= cond_now;
        end
    end

    // NZCV register, updated at the end of an executing S-suffixed instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (in_exec && Funct[0] && cond_ok && cmd_legal) begin
            flags <= ALUFlags;
        end
    end

    // Sticky flag for unsupported opcodes or data-processing commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if ((state == DECODE && Op == 2'b11) || (in_exec && !cmd_legal)) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;

    // Next-state and datapath control decode for the current state.
    always_comb begin
        next_state    = state;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        AdrSrc        = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ImmSrc        = 2'b00;
        RegSrc        = 2'b00;
        ALUControl    = 2'b00;
        case (state)
            FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                next_state   = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = is_store ? 2'b10 : 2'b00;
                case (Op)
                    2'b01:   ImmSrc = 2'b01;
                    2'b10:   ImmSrc = 2'b10;
                    default: ImmSrc = 2'b00;
                endcase
                case (Op)
                    2'b00:   next_state = Funct[5] ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: begin
                        next_state = FETCH;
                        done_raw   = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                next_state = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = cond_ok;
                done_raw      = 1'b1;
                next_state    = FETCH;
            end
            MEMWR: begin
                AdrSrc        = 1'b1;
                RegSrc        = 2'b10;
                mem_write_raw = cond_ok;
                done_raw      = 1'b1;
                next_state    = FETCH;
            end
            EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = alu_op;
                next_state = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b00;
                ALUControl = alu_op;
                next_state = ALUWB;
            end
            ALUWB: begin
                ResultSrc     = 2'b00;
                reg_write_raw = cond_ok && cmd_legal;
                pc_write_raw  = cond_ok && cmd_legal && (Rd == 4'd15);
                done_raw      = 1'b1;
                next_state    = FETCH;
            end
            BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b01;
                ImmSrc       = 2'b10;
                ResultSrc    = 2'b10;
                pc_write_raw = cond_ok;
                done_raw     = 1'b1;
                next_state   = FETCH;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign PCWrite    = pc_write_raw  & rst_n;
    assign IRWrite    = ir_write_raw  & rst_n;
    assign MemWrite   = mem_write_raw & rst_n;
    assign RegWrite   = reg_write_raw & rst_n;
    assign instr_done = done_raw      & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a
// randomized instruction stream compared against an instruction-level model.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic       instr_done;
    logic       illegal;

    int         num_checks;
    int         num_fail;
    logic [3:0] model_flags;
    logic       model_illegal;

    logic [1:0] r_op;
    logic [5:0] r_funct;
    logic [3:0] r_rd;
    logic [3:0] r_cond;
    logic [3:0] r_cmd;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Condition as a base test on NZCV, inverted by the low cond bit.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic base;
        case (c[3:1])
            3'd0:    base = f[2];
            3'd1:    base = f[1];
            3'd2:    base = f[3];
            3'd3:    base = f[0];
            3'd4:    base = f[1] && !f[2];
            3'd5:    base = (f[3] == f[0]);
            3'd6:    base = !f[2] && (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [1:0] model_alu(input logic [3:0] cmd);
        case (cmd)
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        model_flags   = 4'b0000;
        model_illegal = 1'b0;
    endtask

    // Runs one instruction starting at a negedge with the DUT in FETCH and
    // returns at the negedge where the next FETCH begins.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                                 input logic [3:0] cnd, input logic [3:0] af);
        logic is_dp, is_ldr, is_str, is_b, is_ill, legal, c_ok;
        int   exp_lat;
        int   cyc;
        is_dp  = (op == 2'b00);
        is_ldr = (op == 2'b01) && fn[0];
        is_str = (op == 2'b01) && !fn[0];
        is_b   = (op == 2'b10);
        is_ill = (op == 2'b11);
        legal  = !is_dp || (fn[4:1] == 4'b0100) || (fn[4:1] == 4'b0010) ||
                 (fn[4:1] == 4'b0000) || (fn[4:1] == 4'b1100);
        c_ok   = model_cond(cnd, model_flags);
        exp_lat = is_ill ? 2 : is_b ? 3 : is_ldr ? 5 : 4;

        Op = op; Funct = fn; Rd = rd; Cond = cnd; ALUFlags = af;
        #1;
        checkOutput("illegal_sticky", illegal, model_illegal);
        checkOutput("fetch_irwrite", IRWrite, 1);
        checkOutput("fetch_pcwrite", PCWrite, 1);
        cyc = 1;
        while (instr_done !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc == 2) begin
                checkOutput("decode_immsrc", ImmSrc, is_b ? 2 : (op == 2'b01) ? 1 : 0);
                checkOutput("decode_regsrc", RegSrc, is_str ? 2 : 0);
            end
            if (cyc == 3 && is_dp) begin
                checkOutput("exec_alucontrol", ALUControl, model_alu(fn[4:1]));
                checkOutput("exec_alusrcb", ALUSrcB, fn[5] ? 1 : 0);
            end
            if (cyc == 3 && op == 2'b01)
                checkOutput("memadr_immsrc", ImmSrc, 1);
            if (instr_done !== 1'b1)
                checkOutput("mid_writes", {IRWrite, PCWrite, RegWrite, MemWrite}, 0);
        end
        checkOutput("latency", cyc, exp_lat);
        if (instr_done !== 1'b1) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            return;
        end
        checkOutput("last_regwrite", RegWrite, ((is_dp && legal) || is_ldr) && c_ok);
        checkOutput("last_memwrite", MemWrite, is_str && c_ok);
        checkOutput("last_pcwrite", PCWrite, c_ok && (is_b || (is_dp && legal && rd == 4'd15)));
        checkOutput("last_irwrite", IRWrite, 0);
        if (is_ldr) checkOutput("memwb_resultsrc", ResultSrc, 1);
        if (is_dp)  checkOutput("aluwb_resultsrc", ResultSrc, 0);
        if (is_b)   checkOutput("branch_immsrc", ImmSrc, 2);
        if (is_str) checkOutput("memwr_regsrc", RegSrc, 2);
        if (is_dp && fn[0] && legal && c_ok) model_flags = af;
        if (is_ill || !legal) model_illegal = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        num_checks = 0;
        num_fail   = 0;
        model_reset();
        rst_n = 1'b0;
        Op = 2'b00; Funct = 6'd0; Rd = 4'd0; Cond = 4'b1110; ALUFlags = 4'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_irwrite", IRWrite, 0);
        checkOutput("reset_pcwrite", PCWrite, 0);
        checkOutput("reset_done", instr_done, 0);
        checkOutput("reset_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // BEQ with Z clear, ADDS setting Z, BEQ again now taken.
        applyStimulus(2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000);
        applyStimulus(2'b00, 6'b101001, 4'd1, 4'b1110, 4'b0100);
        applyStimulus(2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000);
        // LDR, STR, ADD to PC.
        applyStimulus(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b0000);
        applyStimulus(2'b01, 6'b011000, 4'd3, 4'b1110, 4'b0000);
        applyStimulus(2'b00, 6'b001000, 4'd15, 4'b1110, 4'b0000);

        // Randomized legal instruction stream.
        for (int i = 0; i < 200; i++) begin
            r_op = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       r_cmd = 4'b0100;
                1:       r_cmd = 4'b0010;
                2:       r_cmd = 4'b0000;
                default: r_cmd = 4'b1100;
            endcase
            if (r_op == 2'b00)
                r_funct = {1'($urandom_range(0, 1)), r_cmd, 1'($urandom_range(0, 1))};
            else
                r_funct = 6'($urandom_range(0, 63));
            r_rd   = 4'($urandom_range(0, 15));
            r_cond = ($urandom_range(0, 1) == 1) ? 4'b1110 : 4'($urandom_range(0, 15));
            applyStimulus(r_op, r_funct, r_rd, r_cond, 4'($urandom_range(0, 15)));
        end

        // Reset asserted while a store sits in MEMWR.
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd5; Cond = 4'b1110;
        #1;
        checkOutput("str_fetch_irwrite", IRWrite, 1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("memwr_memwrite", MemWrite, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_memwrite", MemWrite, 0);
        checkOutput("reset_mid_done", instr_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checkOutput("post_reset_fetch", IRWrite, 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Flags cleared by reset: NE taken, EQ not taken.
        applyStimulus(2'b10, 6'b000000, 4'd0, 4'b0001, 4'b0000);
        applyStimulus(2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000);

        // Unsupported cmd, a follow-up instruction, then an unsupported opcode.
        applyStimulus(2'b00, 6'b011110, 4'd4, 4'b1110, 4'b1111);
        applyStimulus(2'b00, 6'b001000, 4'd6, 4'b1110, 4'b0000);
        applyStimulus(2'b11, 6'b000000, 4'd0, 4'b1110, 4'b0000);
        applyStimulus(2'b10, 6'b000000, 4'd0, 4'b1110, 4'b0000);

        rst_n = 1'b0;
        #1;
        checkOutput("reset_clears_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
